router_fifo: RTL and testbench
==============================

// Module: router_fifo
// PURPOSE
//  Per-output-port packet FIFO of the 1x3 router. Sits directly downstream of the
//  enable-gated sync stage: accepts its registered byte stream plus a header flag,
//  buffers it, and drains it to one destination client. Tracks the current packet
//  length so the read side knows where each packet ends.
// PARAMETERS
//  DEPTH  16  entries; power of two, >= 4
//  WIDTH  8   data byte width; header length field = data[WIDTH-1:2]
// PORTS
//  clock       in   1      rising-edge clock
//  resetn      in   1      synchronous active-low reset
//  soft_reset  in   1      synchronous active-high flush (client timeout)
//  write_enb   in   1      write request
//  lfd_state   in   1      1 = data_in is a packet header byte
//  data_in     in   WIDTH  byte to store
//  read_enb    in   1      read request from the client
//  data_out    out  WIDTH  registered read data
//  out_valid   out  1      1 = data_out was updated this cycle (one-cycle pulse per read)
//  pkt_done    out  1      1 = no bytes remain in the packet currently being read
//  full        out  1      DEPTH entries occupied
//  empty       out  1      zero entries occupied
// BEHAVIOUR
//  - Storage: DEPTH x (WIDTH+1) array; entry = {lfd_state, data_in}. Array contents are not reset.
//  - Pointers wr_ptr and rd_ptr, each log2(DEPTH)+1 bits.
//    empty = (wr_ptr == rd_ptr). full = MSBs differ and the low bits are equal.
//    full and empty are combinational from the registered pointers.
//  - Write: on the clock edge when write_enb && !full. Stores the entry at wr_ptr, then wr_ptr+1.
//    A write while full is dropped; the array and the pointers do not change.
//  - Read: on the clock edge when read_enb && !empty.
//    data_out <= mem[rd_ptr] byte; rd_ptr+1; out_valid=1 in the next cycle (1-cycle latency).
//    A read while empty is ignored: out_valid=0, data_out holds.
//  - Simultaneous read and write: both proceed when their own condition holds.
//    Full+both: the read proceeds, the write is dropped (full is sampled before the edge).
//    Empty+both: the write proceeds, the read is ignored (no write-through bypass).
//  - Pointers wrap modulo 2*DEPTH and need no special casing.
//  - Packet counter pkt_cnt (WIDTH-1 bits, unsigned):
//    Reading a header entry: pkt_cnt <= data[WIDTH-1:2] + 1 (payload bytes + parity byte).
//    Reading a non-header entry while pkt_cnt != 0: pkt_cnt <= pkt_cnt - 1.
//    Reading a non-header entry while pkt_cnt == 0: pkt_cnt holds at 0. No underflow.
//  - pkt_done = (pkt_cnt == 0). Combinational from the register. Reads 1 after reset.
//  - Reset (resetn=0), highest priority:
//    pointers=0, pkt_cnt=0, data_out=0, out_valid=0.
//    Hence full=0, empty=1, pkt_done=1.
//  - soft_reset=1 (with resetn=1): same clearing as reset, in the same cycle.
//    Overrides any write or read in that cycle. Legal in the middle of a packet.
//    Flushes all stored bytes.
// TESTING
//  1. resetn=0 for 2 cycles -> empty=1, full=0, pkt_done=1, data_out=8'h00, out_valid=0.
//  2. Write header 8'h0C (length 3, lfd=1), then 11,22,33 and parity 8'h2A; read 5 times ->
//     data_out = 0C,11,22,33,2A, each one cycle after its read; pkt_cnt = 4,3,2,1,0;
//     pkt_done=1 after parity.
//  3. Write 16 bytes -> full=1. 17th write (8'hFF) is dropped.
//     Read 16 -> original order, no FF, empty=1.
//  4. Full with read_enb=write_enb=1 -> one byte out, write dropped, full=0 next cycle.
//     Empty with both asserted -> out_valid=0, entry count becomes 1.
//  5. Write 40 bytes interleaved with reads, never exceeding 10 in flight ->
//     pointer wrap preserves order; no spurious full or empty.
//  6. soft_reset mid-packet after 2 of 5 bytes read -> next cycle empty=1, pkt_done=1,
//     data_out=0. Writing a new header 8'h04 and reading it -> pkt_cnt=2.

Source files
------------

// File: rtl/router_fifo.sv
// router_fifo: per-output-port packet FIFO of the 1x3 router.
// Buffers the byte stream from the sync stage, tagged with a header flag, and
// drains it to one destination client. Tracks the remaining length of the
// packet being read so the client knows where each packet ends.
//
// Ports:
//   clock      - rising-edge clock
//   resetn     - synchronous active-low reset
//   soft_reset - synchronous active-high flush (client timeout)
//   write_enb  - write request
//   lfd_state  - 1 = data_in is a packet header byte
//   data_in    - byte to store
//   read_enb   - read request from the client
//   data_out   - registered read data
//   out_valid  - one-cycle pulse: data_out updated by a read
//   pkt_done   - no bytes remain in the packet being read
//   full       - DEPTH entries occupied
//   empty      - zero entries occupied
module router_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             pkt_done,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH:0]   mem [DEPTH];

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-2:0] pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;

  logic             clear;
  logic             wr_fire;
  logic             rd_fire;
  logic [WIDTH:0]   rd_entry;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pkt_done = (pkt_cnt_q == '0);

  assign clear    = !resetn || soft_reset;
  assign wr_fire  = write_enb && !full;
  assign rd_fire  = read_enb && !empty;
  assign rd_entry = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pkt_cnt_d   = pkt_cnt_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;

    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end

    if (rd_fire) begin
      rd_ptr_d    = rd_ptr_q + (AW+1)'(1);
      data_out_d  = rd_entry[WIDTH-1:0];
      out_valid_d = 1'b1;
      // Header length counts payload bytes; +1 covers the trailing parity byte.
      if (rd_entry[WIDTH]) begin
        pkt_cnt_d = (WIDTH-1)'(rd_entry[WIDTH-1:2]) + (WIDTH-1)'(1);
      end else if (pkt_cnt_q != '0) begin
        pkt_cnt_d = pkt_cnt_q - (WIDTH-1)'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_cnt_q   <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_cnt_q   <= pkt_cnt_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage is not reset; writes are suppressed during a reset or flush.
  always_ff @(posedge clock) begin
    if (!clear && wr_fire) begin
      mem[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo (DEPTH=16, WIDTH=8).
module tb_router_fifo;

  logic       clock = 1'b0;
  logic       resetn;
  logic       soft_reset;
  logic       write_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic       read_enb;
  logic [7:0] data_out;
  logic       out_valid;
  logic       pkt_done;
  logic       full;
  logic       empty;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .read_enb   (read_enb),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .pkt_done   (pkt_done),
    .full       (full),
    .empty      (empty)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic hdr);
    write_enb = 1'b1;
    lfd_state = hdr;
    data_in   = d;
    step();
    write_enb = 1'b0;
    lfd_state = 1'b0;
  endtask

  task automatic rd();
    read_enb = 1'b1;
    step();
    read_enb = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = 8'h00;
    step();
    step();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    n_checks++; if (pkt_done !== 1'b1) begin n_fail++; $display("FAIL reset_pkt_done got=%b exp=1", pkt_done); end
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_packet();
    logic [7:0] pkt [5];
    logic [6:0] cnt [5];
    pkt = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h2A};
    cnt = '{7'd4, 7'd3, 7'd2, 7'd1, 7'd0};
    for (int i = 0; i < 5; i++) wr(pkt[i], i == 0);
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL pkt_not_empty got=%b exp=0", empty); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pkt_no_valid_before_read got=%b exp=0", out_valid); end
    for (int i = 0; i < 5; i++) begin
      rd();
      n_checks++; if (data_out !== pkt[i]) begin n_fail++; $display("FAIL pkt_data[%0d] got=%h exp=%h", i, data_out, pkt[i]); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pkt_valid[%0d] got=%b exp=1", i, out_valid); end
      n_checks++; if (dut.pkt_cnt_q !== cnt[i]) begin n_fail++; $display("FAIL pkt_cnt[%0d] got=%0d exp=%0d", i, dut.pkt_cnt_q, cnt[i]); end
      n_checks++; if (pkt_done !== (i == 4)) begin n_fail++; $display("FAIL pkt_done[%0d] got=%b exp=%b", i, pkt_done, i == 4); end
    end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pkt_valid_idle got=%b exp=0", out_valid); end
    n_checks++; if (data_out !== 8'h2A) begin n_fail++; $display("FAIL pkt_data_hold got=%h exp=2a", data_out); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL pkt_empty_after got=%b exp=1", empty); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 15; i++) wr(8'h10 + 8'(i), 1'b0);
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_at_15 got=%b exp=0", full); end
    wr(8'h1F, 1'b0);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_at_16 got=%b exp=1", full); end
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL full_empty got=%b exp=0", empty); end
    wr(8'hFF, 1'b0);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_after_drop got=%b exp=1", full); end
    for (int i = 0; i < 16; i++) begin
      rd();
      n_checks++; if (data_out !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL full_drain[%0d] got=%h exp=%h", i, data_out, 8'h10 + 8'(i)); end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_drained_empty got=%b exp=1", empty); end
    rd();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_read_empty_valid got=%b exp=0", out_valid); end
    n_checks++; if (data_out !== 8'h1F) begin n_fail++; $display("FAIL full_read_empty_hold got=%h exp=1f", data_out); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) wr(8'h40 + 8'(i), 1'b0);
    write_enb = 1'b1; read_enb = 1'b1; data_in = 8'hEE;
    step();
    write_enb = 1'b0; read_enb = 1'b0;
    n_checks++; if (data_out !== 8'h40) begin n_fail++; $display("FAIL b2b_full_data got=%h exp=40", data_out); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_full_valid got=%b exp=1", out_valid); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL b2b_full_cleared got=%b exp=0", full); end
    for (int i = 1; i < 16; i++) begin
      rd();
      n_checks++; if (data_out !== 8'h40 + 8'(i)) begin n_fail++; $display("FAIL b2b_drain[%0d] got=%h exp=%h", i, data_out, 8'h40 + 8'(i)); end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_write_dropped got=%b exp=1", empty); end
    write_enb = 1'b1; read_enb = 1'b1; data_in = 8'h77;
    step();
    write_enb = 1'b0; read_enb = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty_valid got=%b exp=0", out_valid); end
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL b2b_empty_wrote got=%b exp=0", empty); end
    n_checks++; if (data_out !== 8'h4F) begin n_fail++; $display("FAIL b2b_empty_hold got=%h exp=4f", data_out); end
    rd();
    n_checks++; if (data_out !== 8'h77) begin n_fail++; $display("FAIL b2b_single got=%h exp=77", data_out); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_single_empty got=%b exp=1", empty); end
  endtask

  task automatic test_wrap();
    logic [7:0] q [$];
    logic [7:0] exp_d;
    int         wcnt;
    bit         done;
    bit         do_wr;
    bit         do_rd;
    bit         rd_hit;
    wcnt  = 0;
    done  = 0;
    exp_d = 8'h00;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      do_wr = (wcnt < 40) && (q.size() < 10);
      do_rd = (cyc % 4) != 3;
      write_enb = do_wr;
      read_enb  = do_rd;
      data_in   = 8'hC0 + 8'(wcnt);
      rd_hit = do_rd && (q.size() > 0);
      if (rd_hit) exp_d = q.pop_front();
      if (do_wr) begin
        q.push_back(data_in);
        wcnt++;
      end
      step();
      n_checks++; if (out_valid !== rd_hit) begin n_fail++; $display("FAIL wrap_valid cyc=%0d got=%b exp=%b", cyc, out_valid, rd_hit); end
      if (rd_hit) begin
        n_checks++; if (data_out !== exp_d) begin n_fail++; $display("FAIL wrap_data cyc=%0d got=%h exp=%h", cyc, data_out, exp_d); end
      end
      n_checks++; if (empty !== (q.size() == 0)) begin n_fail++; $display("FAIL wrap_empty cyc=%0d got=%b exp=%b", cyc, empty, q.size() == 0); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL wrap_full cyc=%0d got=%b exp=0", cyc, full); end
      if (wcnt == 40 && q.size() == 0) done = 1;
    end
    write_enb = 1'b0; read_enb = 1'b0;
    n_checks++; if (!done) begin n_fail++; $display("FAIL wrap_timeout got=%0d_written exp=40_drained", wcnt); end
  endtask

  task automatic test_soft_reset();
    wr(8'h0C, 1'b1);
    wr(8'hA1, 1'b0);
    wr(8'hA2, 1'b0);
    wr(8'hA3, 1'b0);
    wr(8'h5B, 1'b0);
    rd();
    rd();
    n_checks++; if (dut.pkt_cnt_q !== 7'd3) begin n_fail++; $display("FAIL sr_mid_cnt got=%0d exp=3", dut.pkt_cnt_q); end
    n_checks++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL sr_mid_done got=%b exp=0", pkt_done); end
    soft_reset = 1'b1; read_enb = 1'b1; write_enb = 1'b1; data_in = 8'h99;
    step();
    soft_reset = 1'b0; read_enb = 1'b0; write_enb = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL sr_empty got=%b exp=1", empty); end
    n_checks++; if (pkt_done !== 1'b1) begin n_fail++; $display("FAIL sr_pkt_done got=%b exp=1", pkt_done); end
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL sr_data_out got=%h exp=00", data_out); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sr_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL sr_full got=%b exp=0", full); end
    wr(8'h04, 1'b1);
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL sr_new_hdr_empty got=%b exp=0", empty); end
    rd();
    n_checks++; if (data_out !== 8'h04) begin n_fail++; $display("FAIL sr_new_hdr_data got=%h exp=04", data_out); end
    n_checks++; if (dut.pkt_cnt_q !== 7'd2) begin n_fail++; $display("FAIL sr_new_hdr_cnt got=%0d exp=2", dut.pkt_cnt_q); end
    n_checks++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL sr_new_hdr_done got=%b exp=0", pkt_done); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL sr_new_hdr_drained got=%b exp=1", empty); end
  endtask

  initial begin
    test_reset();
    test_packet();
    test_full();
    test_back_to_back();
    test_wrap();
    test_soft_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
